// File: rtl/irq_source_ctrl.sv
// Device interrupt front end: synchronizes 30 async request lines, applies mask and
// edge/level mode, and issues registered single-cycle request pulses toward CP0.
module irq_source_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:1] irq_in,
    input  logic [30:1] irq_mode,
    input  logic [30:1] irq_mask,
    input  logic [30:1] lost_clr,
    output logic [30:1] ir_map,
    output logic [30:1] irq_pend,
    output logic [30:1] irq_lost
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [SYNC_STAGES-1:0][30:1] sync_q;
    logic [30:1]                  s;
    logic [30:1]                  prev_q;
    logic [30:1]                  rise;
    logic [CW-1:0]                count_q;
    logic                         tick;

    logic [30:1] next_map;
    logic [30:1] next_pend;
    logic [30:1] next_lost;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign tick = (count_q == CW'(HOLDOFF - 1));

    // NOTE: every flop here uses <= so all stages sample the pre-edge values together;
    // a blocking assignment would collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            count_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q  <= s;
            count_q <= tick ? '0 : count_q + 1'b1;
        end
    end

    // Edge lines pulse on a fresh rise or a pending request once unmasked; level lines
    // pulse on their first rise and then on every shared holdoff tick while still high.
    always_comb begin
        next_map  = irq_mask & ((irq_mode & (rise | irq_pend)) |
                                (~irq_mode & s & (rise | {30{tick}})));
        next_pend = irq_mode & ~irq_mask & (rise | irq_pend);
        next_lost = (irq_lost & ~lost_clr) | (irq_mode & ~irq_mask & rise & irq_pend);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_map   <= '0;
            irq_pend <= '0;
            irq_lost <= '0;
        end else begin
            ir_map   <= next_map;
            irq_pend <= next_pend;
            irq_lost <= next_lost;
        end
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl: edge, level, masking/pend/lost, simultaneous
// lines, reset mid-stream and input glitch capture.
module tb_irq_source_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int HOLDOFF     = 8;

    logic        clk;
    logic        rst_n;
    logic [30:1] irq_in;
    logic [30:1] irq_mode;
    logic [30:1] irq_mask;
    logic [30:1] lost_clr;
    logic [30:1] ir_map;
    logic [30:1] irq_pend;
    logic [30:1] irq_lost;

    int checks;
    int errors;
    int cyc;

    irq_source_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .HOLDOFF    (HOLDOFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_in  (irq_in),
        .irq_mode(irq_mode),
        .irq_mask(irq_mask),
        .lost_clr(lost_clr),
        .ir_map  (ir_map),
        .irq_pend(irq_pend),
        .irq_lost(irq_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:1] bitv(input int i);
        logic [30:1] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Advance one clock; samples and drives happen 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_count(input int n, input int line, output int pulses,
                             output logic [30:1] others);
        pulses = 0;
        others = '0;
        for (int k = 0; k < n; k++) begin
            step();
            if (ir_map[line]) pulses++;
            others = others | (ir_map & ~bitv(line));
        end
    endtask

    int          p;
    int          p_total;
    logic [30:1] o;
    logic        exp_bit;
    int          t0;

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        irq_in   = '0;
        lost_clr = '0;
        irq_mode = ~bitv(12);
        irq_mask = ~(bitv(7) | bitv(3));

        step();
        step();
        check("reset_map", ir_map, '0);
        check("reset_pend", irq_pend, '0);
        check("reset_lost", irq_lost, '0);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        step();

        // 1: edge line 5 held high, exactly one pulse at 3 clocks
        irq_in[5] = 1'b1;
        step();
        step();
        check("edge_early", ir_map, '0);
        step();
        check("edge_pulse", ir_map, bitv(5));
        run_count(47, 5, p, o);
        check("edge_extra_pulses", p, 0);
        check("edge_other_bits", o, '0);
        irq_in[5] = 1'b0;
        run_count(5, 5, p, o);
        check("edge_fall_no_pulse", p, 0);

        // 2: level line 12 held 40 clocks, pulses at first rise and on every tick
        t0         = cyc;
        irq_in[12] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            exp_bit = (cyc == t0 + 3) ||
                      ((cyc % HOLDOFF == 0) && (cyc >= t0 + 3) && (cyc <= t0 + 42));
            check($sformatf("level_c%0d", k), ir_map[12], exp_bit);
            if (k == 40) irq_in[12] = 1'b0;
        end

        // 3: masked edge line 7, pend then lost, unmask pulse, lost_clr
        p_total   = 0;
        irq_in[7] = 1'b1;
        run_count(3, 7, p, o);
        p_total += p;
        check("mask_pend_set", irq_pend[7], 1'b1);
        check("mask_lost_clear", irq_lost[7], 1'b0);
        irq_in[7] = 1'b0;
        run_count(3, 7, p, o);
        p_total += p;
        irq_in[7] = 1'b1;
        run_count(3, 7, p, o);
        p_total += p;
        check("mask_lost_set", irq_lost[7], 1'b1);
        check("mask_no_pulse", p_total, 0);
        irq_mask[7] = 1'b1;
        step();
        check("unmask_pulse", ir_map, bitv(7));
        check("unmask_pend_clr", irq_pend[7], 1'b0);
        step();
        check("unmask_single", ir_map, '0);
        check("lost_sticky", irq_lost[7], 1'b1);
        lost_clr[7] = 1'b1;
        step();
        lost_clr[7] = 1'b0;
        check("lost_cleared", irq_lost[7], 1'b0);
        irq_in[7] = 1'b0;
        step();
        step();
        step();

        // 4: lines 1 and 30 together; lost set wins over coincident lost_clr
        irq_in[1]  = 1'b1;
        irq_in[30] = 1'b1;
        step();
        step();
        step();
        check("simul_pulse", ir_map, bitv(1) | bitv(30));
        step();
        check("simul_single", ir_map, '0);
        irq_in[1]  = 1'b0;
        irq_in[30] = 1'b0;
        irq_in[3]  = 1'b1;
        step();
        step();
        step();
        check("l3_pend", irq_pend[3], 1'b1);
        irq_in[3] = 1'b0;
        step();
        step();
        step();
        irq_in[3] = 1'b1;
        step();
        step();
        check("l3_lost_before", irq_lost[3], 1'b0);
        lost_clr[3] = 1'b1;
        step();
        lost_clr[3] = 1'b0;
        check("l3_lost_priority", irq_lost[3], 1'b1);

        // 5: reset with a pulse in flight and pend/lost set
        irq_in[1] = 1'b1;
        step();
        step();
        step();
        check("pre_rst_map", ir_map, bitv(1));
        check("pre_rst_pend", irq_pend[3], 1'b1);
        irq_in = bitv(12);
        rst_n  = 1'b0;
        #1;
        check("rst_map", ir_map, '0);
        check("rst_pend", irq_pend, '0);
        check("rst_lost", irq_lost, '0);
        step();
        step();
        check("rst_hold_map", ir_map, '0);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        check("post_rst_c1", ir_map, '0);
        step();
        check("post_rst_c2", ir_map, '0);
        step();
        check("post_rst_c3", ir_map, bitv(12));
        irq_in[12] = 1'b0;
        step();
        step();
        step();
        step();

        // 6: glitch inside one clock period is missed, one spanning an edge is caught
        @(posedge clk);
        #2;
        irq_in[9] = 1'b1;
        #4;
        irq_in[9] = 1'b0;
        run_count(8, 9, p, o);
        check("glitch_missed", p, 0);
        irq_in[9] = 1'b1;
        step();
        irq_in[9] = 1'b0;
        run_count(8, 9, p, o);
        check("glitch_caught", p, 1);
        check("glitch_others", o, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
